// File: rtl/cpu_phase_gen_if.sv
// Bus-timing strobe bundle between the phase generator and its consumers.
// Carries cycle_cnt only when CPU_PHASE_CYCLE_CNT_EN is defined.
interface cpu_phase_gen_if;
  logic        halt;
  logic        step;
  logic        ph1;
  logic        ph2;
  logic        ph1_rising;
  logic        ph1_falling;
  logic        ph2_rising;
  logic        ph2_falling;
  logic        even_cycle;
  logic        halted;
`ifdef CPU_PHASE_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
`endif

  // Phase generator side: sources the strobes, receives halt/step.
  modport master (
    input  halt, step,
    output ph1, ph2, ph1_rising, ph1_falling, ph2_rising, ph2_falling,
           even_cycle, halted
`ifdef CPU_PHASE_CYCLE_CNT_EN
    , output cycle_cnt
`endif
  );

  // Consumer / debug side: drives halt/step, observes the strobes.
  modport slave (
    output halt, step,
    input  ph1, ph2, ph1_rising, ph1_falling, ph2_rising, ph2_falling,
           even_cycle, halted
`ifdef CPU_PHASE_CYCLE_CNT_EN
    , input cycle_cnt
`endif
  );
endinterface

// File: rtl/cpu_phase_gen.sv
// CPU two-phase bus strobe generator with halt/single-step freeze on cycle boundaries.
// Optional CPU cycle counter enabled by defining CPU_PHASE_CYCLE_CNT_EN.
module cpu_phase_gen #(
  parameter int PHASE_LEN = 6,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  cpu_phase_gen_if.master  bus
);

  if ((PHASE_LEN < 2) || (PHASE_LEN > 127) || ((1 << CNT_W) < (2 * PHASE_LEN))) begin : g_param_check
    $error("cpu_phase_gen: illegal PHASE_LEN/CNT_W combination");
  end

  localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [CNT_W-1:0] PH1_END_C = CNT_W'(PHASE_LEN - 1);
  localparam logic [CNT_W-1:0] PH_LEN_C  = CNT_W'(PHASE_LEN);
  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(2 * PHASE_LEN - 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             active_r, active_s;
  logic             even_r, even_s;
  logic             boundary_s;
  logic             ph1_r, ph2_r, ph1_rising_r, ph1_falling_r;
  logic             ph2_rising_r, ph2_falling_r, halted_r;

  // Next-state: active_r low in RUN marks the idle clk right after reset.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    active_s   = active_r;
    even_s     = even_r;
    boundary_s = active_r && (cnt_r == LAST_C);
    case (state_r)
      ST_RUN, ST_STEP: begin
        if (!active_r) begin
          active_s = 1'b1;
          cnt_s    = ZERO_C;
        end else if (boundary_s) begin
          even_s = ~even_r;
          cnt_s  = ZERO_C;
          if (bus.halt) begin
            state_s  = ST_HALT;
            active_s = 1'b0;
          end else begin
            state_s  = ST_RUN;
            active_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + ONE_C;
        end
      end
      ST_HALT: begin
        cnt_s = ZERO_C;
        if (bus.step) begin
          state_s  = ST_STEP;
          active_s = 1'b1;
        end else if (!bus.halt) begin
          state_s  = ST_RUN;
          active_s = 1'b1;
        end else begin
          state_s  = ST_HALT;
          active_s = 1'b0;
        end
      end
      default: begin
        state_s  = ST_RUN;
        cnt_s    = ZERO_C;
        active_s = 1'b0;
      end
    endcase
  end

  // FSM state plus strobes registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_RUN;
      cnt_r         <= ZERO_C;
      active_r      <= 1'b0;
      even_r        <= 1'b1;
      ph1_r         <= 1'b1;
      ph2_r         <= 1'b0;
      ph1_rising_r  <= 1'b0;
      ph1_falling_r <= 1'b0;
      ph2_rising_r  <= 1'b0;
      ph2_falling_r <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      active_r      <= active_s;
      even_r        <= even_s;
      ph1_r         <= (cnt_s < PH_LEN_C);
      ph2_r         <= !(cnt_s < PH_LEN_C);
      ph1_rising_r  <= active_s && (cnt_s == ZERO_C);
      ph1_falling_r <= active_s && (cnt_s == PH1_END_C);
      ph2_rising_r  <= active_s && (cnt_s == PH_LEN_C);
      ph2_falling_r <= active_s && (cnt_s == LAST_C);
      halted_r      <= (state_s == ST_HALT);
    end
  end

  assign bus.ph1         = ph1_r;
  assign bus.ph2         = ph2_r;
  assign bus.ph1_rising  = ph1_rising_r;
  assign bus.ph1_falling = ph1_falling_r;
  assign bus.ph2_rising  = ph2_rising_r;
  assign bus.ph2_falling = ph2_falling_r;
  assign bus.even_cycle  = even_r;
  assign bus.halted      = halted_r;

`ifdef CPU_PHASE_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_r;

  // Counts completed CPU cycles; bit 0 tracks ~even_cycle by construction.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_r <= 32'd0;
    end else if (boundary_s) begin
      cycle_cnt_r <= cycle_cnt_r + 32'd1;
    end else begin
      cycle_cnt_r <= cycle_cnt_r;
    end
  end

  assign bus.cycle_cnt = cycle_cnt_r;
`endif

endmodule

// File: tb/tb_cpu_phase_gen.sv
// Self-checking bench for cpu_phase_gen: reset-release table, hand sequences
// for halt/step/reset corners, and random halt/step against a cycle-level model.
module tb_cpu_phase_gen;
  localparam int PL  = 6;
  localparam int CYC = 2 * PL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_phase_gen_if bus_if ();
  cpu_phase_gen #(.PHASE_LEN(PL), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus_if));

  int checks = 0;
  int failures = 0;

  // Model: position inside the CPU cycle, cycles completed, frozen flag.
  bit     m_started;
  bit     m_halted;
  int     m_pos;
  longint m_cyc;

  int n_r1, n_f1, n_r2, n_f2, n_coinc, n_eq, n_halted;

  typedef struct {
    int         clk_idx;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[8];

  // {ph1, ph2, ph1_rising, ph1_falling, ph2_rising, ph2_falling, even_cycle, halted}
  function automatic logic [7:0] dut_vec();
    return {bus_if.ph1, bus_if.ph2, bus_if.ph1_rising, bus_if.ph1_falling,
            bus_if.ph2_rising, bus_if.ph2_falling, bus_if.even_cycle, bus_if.halted};
  endfunction

  function automatic logic [7:0] model_vec();
    bit active;
    int pos;
    active = m_started && !m_halted;
    pos    = active ? m_pos : 0;
    return {pos < PL, pos >= PL,
            active && pos == 0, active && pos == PL - 1,
            active && pos == PL, active && pos == CYC - 1,
            (m_cyc % 2) == 0, m_halted};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_started = 1'b0;
      m_halted  = 1'b0;
      m_pos     = 0;
      m_cyc     = 0;
    end else if (!m_started) begin
      m_started = 1'b1;
      m_pos     = 0;
    end else if (m_halted) begin
      if (bus_if.step || !bus_if.halt) begin
        m_halted = 1'b0;
        m_pos    = 0;
      end
    end else if (m_pos == CYC - 1) begin
      m_cyc++;
      m_pos = 0;
      if (bus_if.halt) m_halted = 1'b1;
    end else begin
      m_pos++;
    end
  endtask

  task automatic zero_counts();
    n_r1 = 0; n_f1 = 0; n_r2 = 0; n_f2 = 0; n_coinc = 0; n_eq = 0; n_halted = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model", dut_vec(), model_vec());
`ifdef CPU_PHASE_CYCLE_CNT_EN
    checks++;
    if (bus_if.cycle_cnt !== m_cyc[31:0]) begin
      failures++;
      $display("FAIL cycle_cnt got=%0d expected=%0d", bus_if.cycle_cnt, m_cyc[31:0]);
    end
`endif
    n_r1     += int'(bus_if.ph1_rising);
    n_f1     += int'(bus_if.ph1_falling);
    n_r2     += int'(bus_if.ph2_rising);
    n_f2     += int'(bus_if.ph2_falling);
    n_coinc  += int'(bus_if.ph1_rising & bus_if.ph2_falling);
    n_eq     += int'(bus_if.ph1 == bus_if.ph2);
    n_halted += int'(bus_if.halted);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{0,  8'b1010_0010};
    tbl[1] = '{1,  8'b1000_0010};
    tbl[2] = '{5,  8'b1001_0010};
    tbl[3] = '{6,  8'b0100_1010};
    tbl[4] = '{11, 8'b0100_0110};
    tbl[5] = '{12, 8'b1010_0000};
    tbl[6] = '{13, 8'b1000_0000};
    tbl[7] = '{23, 8'b0100_0100};

    bus_if.halt = 1'b0;
    bus_if.step = 1'b0;
    zero_counts();

    // Reset state and release timing table.
    rst = 1'b1;
    repeat (3) tick();
    check("reset_state", dut_vec(), 8'b1000_0010);
    rst = 1'b0;
    for (int c = 0; c < 24; c++) begin
      tick();
      for (int k = 0; k < 8; k++)
        if (tbl[k].clk_idx == c) check($sformatf("release_clk%0d", c), dut_vec(), tbl[k].exp);
    end

    // Free run of 1000 CPU cycles.
    zero_counts();
    repeat (1000 * CYC) tick();
    check_int("free_ph1_rising", n_r1, 1000);
    check_int("free_ph1_falling", n_f1, 1000);
    check_int("free_ph2_rising", n_r2, 1000);
    check_int("free_ph2_falling", n_f2, 1000);
    check_int("free_coincident", n_coinc, 0);
    check_int("free_ph2_eq_ph1", n_eq, 0);

    // Halt raised at clk 3 of cycle 4.
    do_reset();
    for (int c = 0; c < 52; c++) tick();
    bus_if.halt = 1'b1;
    for (int c = 52; c < 60; c++) tick();
    check("halt_clk59", dut_vec(), 8'b0100_0110);
    tick();
    check("halt_clk60", dut_vec(), 8'b1000_0001);
    zero_counts();
    repeat (20) tick();
    check_int("halt_no_pulses", n_r1 + n_f1 + n_r2 + n_f2, 0);
    check_int("halt_held", n_halted, 20);

    // Single step with halt held.
    zero_counts();
    bus_if.step = 1'b1;
    tick();
    bus_if.step = 1'b0;
    repeat (CYC - 1) tick();
    check_int("step_ph1_rising", n_r1, 1);
    check_int("step_ph1_falling", n_f1, 1);
    check_int("step_ph2_rising", n_r2, 1);
    check_int("step_ph2_falling", n_f2, 1);
    check_int("step_not_halted", n_halted, 0);
    tick();
    check("step_rehalt", dut_vec(), 8'b1000_0011);

    // Step and release together: step wins, then runs freely.
    repeat (3) tick();
    bus_if.halt = 1'b0;
    bus_if.step = 1'b1;
    tick();
    bus_if.step = 1'b0;
    repeat (CYC + 5) tick();

    // Step while running is ignored.
    zero_counts();
    bus_if.step = 1'b1;
    tick();
    bus_if.step = 1'b0;
    repeat (2 * CYC) tick();
    check_int("run_step_ignored", n_halted, 0);

    // Reset asserted at div_cnt 8.
    do_reset();
    for (int c = 0; c < 9; c++) tick();
    rst = 1'b1;
    zero_counts();
    repeat (5) tick();
    check_int("midreset_no_pulses", n_r1 + n_f1 + n_r2 + n_f2, 0);
    check("midreset_state", dut_vec(), 8'b1000_0010);
    rst = 1'b0;
    tick();
    check("midreset_release", dut_vec(), 8'b1010_0010);

    // Random halt/step/reset traffic against the model.
    repeat (4000) begin
      bus_if.halt = ($urandom_range(0, 3) == 0);
      bus_if.step = ($urandom_range(0, 15) == 0);
      rst         = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    bus_if.halt = 1'b0;
    bus_if.step = 1'b0;
    repeat (2 * CYC) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_phase_gen.md
Name: cpu_phase_gen

Overview:
- Generates the CPU bus timing strobes from the single fabric clock: phase pulses ph1_rising, ph1_falling, ph2_rising, ph2_falling; phase levels ph1 and ph2; and the even_cycle flag.
- Sits directly upstream of the sprite DMA, the CPU core and the bus decoders. All of them advance state only on these strobes.
- Supports a halt request for debug single-stepping. Halting freezes the bus cleanly on a CPU-cycle boundary.

Parameters:
- PHASE_LEN, 6: clk periods per phase. One CPU cycle = 2*PHASE_LEN clk periods. Legal values are 2..127. An illegal value is an elaboration error.
- CNT_W, 8: width of the internal phase counter. Must satisfy 2^CNT_W >= 2*PHASE_LEN.

Ports:
- clk  in  1  fabric clock, single clock domain
- rst  in  1  synchronous, active-high reset
- halt  in  1  freeze request. Sampled only at the CPU-cycle boundary.
- step  in  1  one-clk pulse. While halted, releases exactly one CPU cycle.
- ph1  out  1  phase-1 level
- ph2  out  1  phase-2 level, always equal to ~ph1 while running
- ph1_rising  out  1  one-clk pulse at the start of phase 1
- ph1_falling  out  1  one-clk pulse at the end of phase 1
- ph2_rising  out  1  one-clk pulse at the start of phase 2
- ph2_falling  out  1  one-clk pulse on the last clk of phase 2, i.e. the end of the CPU cycle
- even_cycle  out  1  high during even-numbered CPU cycles. Cycle 0 follows reset.
- halted  out  1  high while frozen at a boundary

Behaviour:
- Phase counter:
  - div_cnt counts 0..2*PHASE_LEN-1, increments by 1 per clk and wraps to 0.
  - ph1 = (div_cnt < PHASE_LEN); ph2 = ~ph1.
- Strobe decode (all registered state, no combinational path from inputs):
  - ph1_rising = running & div_cnt==0
  - ph1_falling = running & div_cnt==PHASE_LEN-1
  - ph2_rising = running & div_cnt==PHASE_LEN
  - ph2_falling = running & div_cnt==2*PHASE_LEN-1
- Strobe ordering guarantee: ph2_falling and the following ph1_rising fall on consecutive clks, never the same clk. Consumers update state on ph2_falling and drive bus outputs on ph1_rising.
- even_cycle:
  - Toggles on the clk edge that ends the ph2_falling clk.
  - On the ph2_falling clk it still reflects the cycle that is ending.
- FSM states:
  - RUN:
    - Counter advances.
    - If div_cnt==2*PHASE_LEN-1 and halt==1, go to HALT on the next edge with div_cnt=0.
    - ph2_falling and the even_cycle toggle still occur for the ending cycle.
  - HALT:
    - div_cnt held at 0. All four pulses are 0; ph1=1, ph2=0, halted=1, even_cycle frozen.
    - step==1 goes to STEP.
    - halt==0 (with step==0) goes to RUN.
    - If both halt==0 and step==1, step wins: STEP is taken.
  - STEP:
    - Runs exactly one CPU cycle of 2*PHASE_LEN clks with normal pulses.
    - At its ph2_falling: return to HALT if halt==1, else go to RUN.
  - halted = (state==HALT).
- Pulses in STEP are identical to RUN, including ph1_rising on the first clk.
- halt asserted mid-cycle has no effect until the boundary.
- step outside HALT is ignored.
- Reset:
  - While rst==1: state=RUN, div_cnt=0, even_cycle=1, all pulses=0, ph1=1, ph2=0, halted=0.
  - The first clk with rst==0 produces ph1_rising=1 (cycle 0, even).
  - A reset asserted mid-cycle aborts the cycle immediately; no trailing ph2_falling is emitted.

Optional Feature:
- Macro: CPU_PHASE_CYCLE_CNT_EN.
- Defined:
  - Adds output port cycle_cnt [31:0] with reset value 0.
  - Increments on every ph2_falling and wraps 0xFFFFFFFF→0.
  - Frozen in HALT.
  - cycle_cnt[0] == ~even_cycle at all times.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, PHASE_LEN=6 -> ph1_rising at clk 0; ph1_falling clk 5; ph2_rising clk 6; ph2_falling clk 11; ph1_rising again clk 12; even_cycle=1 for clks 0-11, 0 for clks 12-23.
- 1000 cycles free-run -> exactly one of each pulse per 12 clks; ph2_falling never coincident with ph1_rising; ph2==~ph1 on every clk.
- halt=1 raised at clk 3 of cycle 4 -> cycle 4 completes with ph2_falling at clk 59; halted=1 from clk 60; no pulses afterwards; ph1=1; even_cycle=0 (cycle 5 pending).
- While halted, single step pulse with halt held 1 -> exactly 12 clks of normal pulses, even_cycle toggles once, then halted=1 again; step while running is ignored.
- rst asserted at div_cnt=8 -> pulses drop to 0 on the next clk, no ph2_falling; after release ph1_rising on the first clk and even_cycle=1.
- With CPU_PHASE_CYCLE_CNT_EN, preload via 2^32 wrap check (force 0xFFFFFFFF) -> next ph2_falling gives cycle_cnt=0; cycle_cnt held while halted.
